// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard levels in from the datapath, stage enables/flushes out.
// master = sequencing controller, slave = pipeline datapath.
interface pipe_ctrl_if;
  logic       lu_hazard_D;
  logic       md_use_D;
  logic       md_start_E;
  logic       md_is_div_E;
  logic       exc_req_M;
  logic       eret_D;
  logic       epc_wr_pending;
  logic       en_PC;
  logic       en_FD;
  logic       flush_FD;
  logic       clr_DE;
  logic       clr_EM;
  logic [1:0] pc_sel;
  logic       md_busy;
  logic [3:0] md_cnt;
  logic [1:0] state;

  modport master (
    input  lu_hazard_D, md_use_D, md_start_E, md_is_div_E, exc_req_M, eret_D, epc_wr_pending,
    output en_PC, en_FD, flush_FD, clr_DE, clr_EM, pc_sel, md_busy, md_cnt, state
  );

  modport slave (
    output lu_hazard_D, md_use_D, md_start_E, md_is_div_E, exc_req_M, eret_D, epc_wr_pending,
    input  en_PC, en_FD, flush_FD, clr_DE, clr_EM, pc_sel, md_busy, md_cnt, state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage MIPS sequencing: reset > exception > ERET > stall > normal, plus mult/div busy counter.
// Enables/flushes are zero-latency combinational; backpressure is a PC/F-D hold with a D/E bubble.
module pipe_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.master pif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic       md_go;
  logic       busy;
  logic       stall;

  logic       en_pc;
  logic       en_fd;
  logic       flush_fd;
  logic       clr_de;
  logic       clr_em;
  logic [1:0] pc_sel;

  // A start coinciding with an exception belongs to a squashed instruction.
  assign md_go = pif.md_start_E & ~pif.exc_req_M;
  assign busy  = (cnt_q != 4'd0) | md_go;
  assign stall = pif.lu_hazard_D | (pif.md_use_D & busy);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (md_go) begin
      cnt_q <= pif.md_is_div_E ? 4'(DIV_LAT) : 4'(MULT_LAT);
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = RUN;
    en_pc    = 1'b1;
    en_fd    = 1'b1;
    flush_fd = 1'b0;
    clr_de   = 1'b0;
    clr_em   = 1'b0;
    pc_sel   = 2'd0;

    if (reset) begin
      flush_fd = 1'b1;
      clr_de   = 1'b1;
      clr_em   = 1'b1;
    end else if (pif.exc_req_M) begin
      // pc_sel 1 steers fetch to the exception vector 32'h00004180.
      pc_sel   = 2'd1;
      flush_fd = 1'b1;
      clr_de   = 1'b1;
      clr_em   = 1'b1;
      state_d  = REDIR;
    end else if (state_q == REDIR) begin
      // D holds the bubble from the redirect, so its hazard/ERET bits are stale.
      state_d = RUN;
    end else if (pif.eret_D) begin
      if (pif.epc_wr_pending) begin
        en_pc   = 1'b0;
        en_fd   = 1'b0;
        clr_de  = 1'b1;
        state_d = HOLD;
      end else begin
        // F/D reset+enable with ERET in D loads EPC into PC_D.
        pc_sel   = 2'd2;
        flush_fd = 1'b1;
        state_d  = REDIR;
      end
    end else if (stall) begin
      en_pc  = 1'b0;
      en_fd  = 1'b0;
      clr_de = 1'b1;
    end
  end

  assign pif.en_PC    = en_pc;
  assign pif.en_FD    = en_fd;
  assign pif.flush_FD = flush_fd;
  assign pif.clr_DE   = clr_de;
  assign pif.clr_EM   = clr_em;
  assign pif.pc_sel   = pc_sel;
  assign pif.md_busy  = busy & ~reset;
  assign pif.md_cnt   = cnt_q;
  assign pif.state    = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural model of pipe_ctrl.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_ctrl_if pif ();
  pipe_ctrl dut (.clk(clk), .reset(reset), .pif(pif));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: cycles of mult/div work left, waiting-on-EPC flag, just-redirected flag.
  int m_left  = 0;
  bit m_wait  = 0;
  bit m_after = 0;
  bit primed  = 0;

  bit       e_en_pc, e_en_fd, e_flush_fd, e_clr_de, e_clr_em, e_busy;
  bit [1:0] e_pc_sel;
  int       e_state;

  task automatic model_step();
    bit starting, was_after;
    if (reset) begin
      m_left = 0; m_wait = 0; m_after = 0;
    end else begin
      starting = pif.md_start_E && !pif.exc_req_M;
      if (starting) m_left = pif.md_is_div_E ? 10 : 5;
      else if (m_left > 0) m_left = m_left - 1;
      was_after = m_after;
      m_after = pif.exc_req_M || (!was_after && pif.eret_D && !pif.epc_wr_pending);
      m_wait  = !pif.exc_req_M && !was_after && pif.eret_D && pif.epc_wr_pending;
    end
  endtask

  task automatic model_outputs();
    bit working;
    working = (m_left > 0) || (pif.md_start_E && !pif.exc_req_M);
    e_busy = working && !reset;
    e_en_pc = 1; e_en_fd = 1; e_flush_fd = 0; e_clr_de = 0; e_clr_em = 0; e_pc_sel = 0;
    e_state = m_after ? 2 : (m_wait ? 1 : 0);
    if (reset) begin
      e_flush_fd = 1; e_clr_de = 1; e_clr_em = 1;
    end else if (pif.exc_req_M) begin
      e_pc_sel = 1; e_flush_fd = 1; e_clr_de = 1; e_clr_em = 1;
    end else if (m_after) begin
      e_pc_sel = 0;
    end else if (pif.eret_D && pif.epc_wr_pending) begin
      e_en_pc = 0; e_en_fd = 0; e_clr_de = 1;
    end else if (pif.eret_D) begin
      e_pc_sel = 2; e_flush_fd = 1;
    end else if (pif.lu_hazard_D || (pif.md_use_D && working)) begin
      e_en_pc = 0; e_en_fd = 0; e_clr_de = 1;
    end
  endtask

  // Advance the model over the edge just passed, then drive the next cycle's inputs.
  task automatic apply(input bit r, lu, mdu, mds, mdd, ex, er, ep);
    if (primed) model_step();
    primed = 1;
    @(negedge clk);
    reset = r;
    pif.lu_hazard_D = lu; pif.md_use_D = mdu; pif.md_start_E = mds; pif.md_is_div_E = mdd;
    pif.exc_req_M = ex; pif.eret_D = er; pif.epc_wr_pending = ep;
    cyc++;
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 0, 1, 0, 0, 0, 0);
      checks++; if ({pif.flush_FD, pif.clr_DE, pif.clr_EM} !== 3'b111) begin errors++; $display("FAIL rst_clears cyc %0d got %b exp 111", cyc, {pif.flush_FD, pif.clr_DE, pif.clr_EM}); end
      checks++; if (pif.pc_sel !== 2'd0) begin errors++; $display("FAIL rst_pc_sel got %0d exp 0", pif.pc_sel); end
      checks++; if (pif.md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_busy got %b exp 0", pif.md_busy); end
    end
    idle();
    checks++; if (pif.md_cnt !== 4'd0) begin errors++; $display("FAIL rst_md_cnt got %0d exp 0", pif.md_cnt); end
    checks++; if (pif.state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", pif.state); end
    checks++; if ({pif.en_PC, pif.en_FD} !== 2'b11) begin errors++; $display("FAIL rst_release_en got %b exp 11", {pif.en_PC, pif.en_FD}); end
  endtask

  task automatic test_mult_stall();
    int stalls = 0;
    apply(0, 0, 1, 1, 0, 0, 0, 0);
    checks++; if (pif.md_busy !== 1'b1) begin errors++; $display("FAIL mult_busy_start got %b exp 1", pif.md_busy); end
    if (pif.en_PC === 1'b0) stalls++;
    for (int k = 5; k >= 1; k--) begin
      apply(0, 0, 1, 0, 0, 0, 0, 0);
      checks++; if (pif.md_cnt !== 4'(k)) begin errors++; $display("FAIL mult_cnt got %0d exp %0d", pif.md_cnt, k); end
      checks++; if (pif.clr_DE !== 1'b1) begin errors++; $display("FAIL mult_clr_de cnt %0d got %b exp 1", k, pif.clr_DE); end
      if (pif.en_PC === 1'b0) stalls++;
    end
    apply(0, 0, 1, 0, 0, 0, 0, 0);
    checks++; if (pif.md_cnt !== 4'd0) begin errors++; $display("FAIL mult_cnt_end got %0d exp 0", pif.md_cnt); end
    checks++; if (pif.en_PC !== 1'b1) begin errors++; $display("FAIL mult_release got %b exp 1", pif.en_PC); end
    checks++; if (stalls != 6) begin errors++; $display("FAIL mult_stall_len got %0d exp 6", stalls); end
    idle();
  endtask

  task automatic test_div_exc();
    apply(0, 0, 0, 1, 1, 0, 0, 0);
    idle();
    checks++; if (pif.md_cnt !== 4'd10) begin errors++; $display("FAIL div_load got %0d exp 10", pif.md_cnt); end
    idle();
    apply(0, 0, 0, 0, 0, 1, 0, 0);
    checks++; if (pif.pc_sel !== 2'd1) begin errors++; $display("FAIL exc_pc_sel got %0d exp 1", pif.pc_sel); end
    checks++; if ({pif.flush_FD, pif.clr_DE, pif.clr_EM, pif.en_PC} !== 4'b1111) begin errors++; $display("FAIL exc_ctl got %b exp 1111", {pif.flush_FD, pif.clr_DE, pif.clr_EM, pif.en_PC}); end
    checks++; if (pif.md_cnt !== 4'd8) begin errors++; $display("FAIL exc_cnt got %0d exp 8", pif.md_cnt); end
    idle();
    checks++; if ({pif.state, pif.md_cnt} !== {2'd2, 4'd7}) begin errors++; $display("FAIL exc_redir state/cnt got %0d/%0d exp 2/7", pif.state, pif.md_cnt); end
    idle();
    checks++; if ({pif.state, pif.md_cnt} !== {2'd0, 4'd6}) begin errors++; $display("FAIL exc_run state/cnt got %0d/%0d exp 0/6", pif.state, pif.md_cnt); end
    for (int i = 0; i < 6; i++) idle();
    checks++; if (pif.md_cnt !== 4'd0) begin errors++; $display("FAIL div_drain got %0d exp 0", pif.md_cnt); end
  endtask

  task automatic test_eret_hold();
    apply(0, 0, 0, 0, 0, 0, 1, 1);
    checks++; if ({pif.en_FD, pif.en_PC, pif.clr_DE} !== 3'b001) begin errors++; $display("FAIL hold1 en_fd/en_pc/clr_de got %b exp 001", {pif.en_FD, pif.en_PC, pif.clr_DE}); end
    apply(0, 0, 0, 0, 0, 0, 1, 1);
    checks++; if ({pif.state, pif.en_FD} !== {2'd1, 1'b0}) begin errors++; $display("FAIL hold2 state/en_fd got %0d/%b exp 1/0", pif.state, pif.en_FD); end
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    checks++; if (pif.state !== 2'd1) begin errors++; $display("FAIL hold3_state got %0d exp 1", pif.state); end
    checks++; if ({pif.pc_sel, pif.flush_FD, pif.en_FD, pif.en_PC} !== {2'd2, 3'b111}) begin errors++; $display("FAIL eret_redir got %b exp 10111", {pif.pc_sel, pif.flush_FD, pif.en_FD, pif.en_PC}); end
    apply(0, 1, 0, 0, 0, 0, 1, 1);
    checks++; if ({pif.state, pif.en_PC, pif.pc_sel} !== {2'd2, 1'b1, 2'd0}) begin errors++; $display("FAIL redir_ignores got %b exp 10100", {pif.state, pif.en_PC, pif.pc_sel}); end
    idle();
    checks++; if (pif.state !== 2'd0) begin errors++; $display("FAIL eret_back_run got %0d exp 0", pif.state); end
  endtask

  task automatic test_hold_exc();
    apply(0, 0, 0, 0, 0, 0, 1, 1);
    apply(0, 0, 0, 0, 0, 1, 1, 1);
    checks++; if (pif.pc_sel !== 2'd1) begin errors++; $display("FAIL hold_exc_pc_sel got %0d exp 1", pif.pc_sel); end
    idle();
    checks++; if (pif.state !== 2'd2) begin errors++; $display("FAIL hold_exc_state got %0d exp 2", pif.state); end
    idle();
  endtask

  task automatic test_start_exc();
    apply(0, 0, 1, 1, 0, 1, 0, 0);
    checks++; if ({pif.md_busy, pif.pc_sel} !== {1'b0, 2'd1}) begin errors++; $display("FAIL start_exc busy/pc_sel got %b/%0d exp 0/1", pif.md_busy, pif.pc_sel); end
    idle();
    checks++; if (pif.md_cnt !== 4'd0) begin errors++; $display("FAIL start_exc_cnt got %0d exp 0", pif.md_cnt); end
    idle();
  endtask

  task automatic test_eret_over_hazard();
    apply(0, 1, 0, 0, 0, 0, 1, 0);
    checks++; if ({pif.pc_sel, pif.en_PC, pif.clr_DE} !== {2'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL eret_hazard got %b exp 1010", {pif.pc_sel, pif.en_PC, pif.clr_DE}); end
    idle(); idle();
  endtask

  task automatic test_reset_mid();
    apply(0, 0, 0, 1, 1, 0, 0, 0);
    idle();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    checks++; if (pif.md_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d exp 0", pif.md_cnt); end
    apply(0, 0, 0, 0, 0, 0, 1, 1);
    apply(1, 0, 0, 0, 0, 0, 1, 1);
    idle();
    checks++; if (pif.state !== 2'd0) begin errors++; $display("FAIL rst_mid_hold got %0d exp 0", pif.state); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(99) < 2, $urandom_range(99) < 20, $urandom_range(99) < 30,
            $urandom_range(99) < 15, $urandom_range(1), $urandom_range(99) < 5,
            $urandom_range(99) < 15, $urandom_range(1));
      model_outputs();
      checks++; if ({pif.en_PC, pif.en_FD, pif.flush_FD, pif.clr_DE, pif.clr_EM} !== {e_en_pc, e_en_fd, e_flush_fd, e_clr_de, e_clr_em})
        begin errors++; $display("FAIL rnd_ctl cyc %0d got %b exp %b", cyc, {pif.en_PC, pif.en_FD, pif.flush_FD, pif.clr_DE, pif.clr_EM}, {e_en_pc, e_en_fd, e_flush_fd, e_clr_de, e_clr_em}); end
      checks++; if (pif.pc_sel !== e_pc_sel) begin errors++; $display("FAIL rnd_pc_sel cyc %0d got %0d exp %0d", cyc, pif.pc_sel, e_pc_sel); end
      checks++; if (pif.md_busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", cyc, pif.md_busy, e_busy); end
      checks++; if (pif.md_cnt !== 4'(m_left)) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", cyc, pif.md_cnt, m_left); end
      checks++; if (pif.state !== 2'(e_state)) begin errors++; $display("FAIL rnd_state cyc %0d got %0d exp %0d", cyc, pif.state, e_state); end
    end
  endtask

  initial begin
    reset = 1'b1;
    pif.lu_hazard_D = 0; pif.md_use_D = 0; pif.md_start_E = 0; pif.md_is_div_E = 0;
    pif.exc_req_M = 0; pif.eret_D = 0; pif.epc_wr_pending = 0;
    test_reset();
    test_mult_stall();
    test_div_exc();
    test_eret_hold();
    test_hold_exc();
    test_start_exc();
    test_eret_over_hazard();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
